// File: rtl/aec_result_fmt.sv
// Result formatter: buffers evaluator results in a FIFO and streams each one as
// two lowercase hex digits (or decimal when AEC_FMT_DEC_EN is defined) plus 0x0A.
module aec_result_fmt #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_valid,
  input  logic [6:0] res_data,
  output logic       char_valid,
  output logic [7:0] char_data,
  input  logic       char_ready,
  output logic       overflow,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef AEC_FMT_DEC_EN
  localparam int WORK_W = 7;
`else
  localparam int WORK_W = 4;
`endif

  typedef enum logic [2:0] {IDLE, DIG2, DIG1, DIG0, TERM} state_t;

  logic [6:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  state_t            state_q, state_d;
  logic [WORK_W-1:0] work_q, work_d;
  logic              char_valid_q, char_valid_d;
  logic [7:0]        char_data_q, char_data_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              busy_q, busy_d;
  logic              full, push, pop, xfer;
  logic [6:0]        head;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
  endfunction

`ifdef AEC_FMT_DEC_EN
  // Returns {tens, ones}; tens found by comparing against multiples of ten.
  function automatic logic [7:0] dec_split(input logic [6:0] v);
    logic [6:0] r;
    logic [3:0] t;
    r = (v >= 7'd100) ? v - 7'd100 : v;
    t = 4'd0;
    for (int k = 9; k >= 1; k--) begin
      if (t == 4'd0 && r >= 7'(10 * k)) t = 4'(k);
    end
    return {t, 4'(r - 7'(10 * t))};
  endfunction

  logic [7:0] head_dec, work_dec;
  logic       head_hund;
  assign head_dec  = dec_split(head);
  assign work_dec  = dec_split(work_q);
  assign head_hund = (head >= 7'd100);
`endif

  assign full = (occ_q == CNT_W'(FIFO_DEPTH));
  assign pop  = (state_q == IDLE) && (occ_q != '0);
  assign head = mem_q[rd_ptr_q];
  assign xfer = char_valid_q && char_ready;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    push       = res_valid && !full;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    overflow_d = res_valid && full;
    drop_cnt_d = drop_cnt_q;
    if (overflow_d && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    rd_ptr_d     = rd_ptr_q;
    char_valid_d = char_valid_q;
    char_data_d  = char_data_q;
    case (state_q)
      IDLE: if (pop) begin
        work_d       = head[WORK_W-1:0];
        rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        char_valid_d = 1'b1;
`ifdef AEC_FMT_DEC_EN
        if (head_hund) begin
          state_d     = DIG2;
          char_data_d = 8'h31;
        end else if (head_dec[7:4] != 4'd0) begin
          state_d     = DIG1;
          char_data_d = hex_char(head_dec[7:4]);
        end else begin
          state_d     = DIG0;
          char_data_d = hex_char(head_dec[3:0]);
        end
`else
        state_d     = DIG1;
        char_data_d = hex_char({1'b0, head[6:4]});
`endif
      end
`ifdef AEC_FMT_DEC_EN
      DIG2: if (xfer) begin
        state_d     = DIG1;
        char_data_d = hex_char(work_dec[7:4]);
      end
`endif
      DIG1: if (xfer) begin
        state_d     = DIG0;
`ifdef AEC_FMT_DEC_EN
        char_data_d = hex_char(work_dec[3:0]);
`else
        char_data_d = hex_char(work_q);
`endif
      end
      DIG0: if (xfer) begin
        state_d     = TERM;
        char_data_d = 8'h0A;
      end
      TERM: if (xfer) begin
        state_d      = IDLE;
        char_valid_d = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        char_valid_d = 1'b0;
      end
    endcase
    busy_d = (occ_d != '0) || (state_d != IDLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      state_q      <= IDLE;
      work_q       <= '0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      state_q      <= state_d;
      work_q       <= work_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      busy_q       <= busy_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_data;
  end

  assign char_valid = char_valid_q;
  assign char_data  = char_data_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = busy_q;

endmodule
